line_xfer_ctrl: RTL and testbench

Parametrised successor to the AFU's word/cache-line memory controller. Converts single-word CPU load/store streams into whole-cache-line DMA transfers, with generic word width, line width and address width. It also performs N-region address translation internally. Sits between the CPU's op/address/data-bus ports and the DMA channel handshakes inside the AFU.

---
 rtl/line_xfer_pkg.sv | 28 ++
 rtl/line_xfer_ctrl_region_xlate.sv | 28 ++
 rtl/line_xfer_ctrl.sv | 167 ++++++++++++++++
 tb/tb_line_xfer_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_xfer_pkg.sv
// Shared types and helpers for the word-to-cache-line transfer controller.
package line_xfer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_STREAM,
    ST_WR_FILL,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DONE
  } state_e;

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  function automatic int calc_wpl(input int line_w, input int word_w);
    return line_w / word_w;
  endfunction

  // A one-word line still needs a 1-bit index so ports and compares stay legal.
  function automatic int calc_idx_w(input int wpl);
    return (wpl > 1) ? $clog2(wpl) : 1;
  endfunction

endpackage

// File: rtl/line_xfer_ctrl_region_xlate.sv
// Region translation: top address bits pick a base, the remaining bits are added as offset.
module region_xlate #(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W      = 64
) (
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
  output logic [ADDR_W-1:0]             xlate_addr
);

  logic [ADDR_W-1:0] base_arr [NUM_REGIONS];

  for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_base
    assign base_arr[gi] = region_base[gi*ADDR_W +: ADDR_W];
  end

  if (NUM_REGIONS == 1) begin : g_single
    assign xlate_addr = base_arr[0] + cpu_addr;
  end else begin : g_multi
    localparam int RB = $clog2(NUM_REGIONS);
    logic [RB-1:0]     sel;
    logic [ADDR_W-1:0] offset;
    assign sel        = cpu_addr[ADDR_W-1 -: RB];
    assign offset     = {{RB{1'b0}}, cpu_addr[ADDR_W-RB-1:0]};
    assign xlate_addr = base_arr[sel] + offset;
  end

endmodule

// File: rtl/line_xfer_ctrl.sv
// Turns single-word CPU load/store streams into whole-line DMA read/write transfers
// with region-based address translation latched at command accept.
import line_xfer_pkg::*;

module line_xfer_ctrl #(
  parameter int WORD_W      = 32,
  parameter int LINE_W      = 512,
  parameter int ADDR_W      = 64,
  parameter int NUM_REGIONS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          host_init,
  input  logic [1:0]                    op,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
  input  logic [WORD_W-1:0]             cpu_wr_data,
  input  logic                          cpu_wr_valid,
  output logic                          cpu_wr_ready,
  output logic [WORD_W-1:0]             cpu_rd_data,
  output logic                          cpu_rd_valid,
  output logic                          ready,
  output logic                          tx_done,
  output logic [ADDR_W-1:0]             host_addr,
  output logic                          host_rd_go,
  output logic                          host_wr_go,
  input  logic                          host_rd_ready,
  output logic                          host_re,
  input  logic [LINE_W-1:0]             host_rd_data,
  input  logic                          host_wr_ready,
  output logic                          host_we,
  output logic [LINE_W-1:0]             host_wr_data
);

  localparam int WPL   = calc_wpl(LINE_W, WORD_W);
  localparam int IDX_W = calc_idx_w(WPL);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WPL - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [ADDR_W-1:0]   host_addr_q, host_addr_d;
  logic                ready_q, ready_d;
  logic                rd_go_q, rd_go_d;
  logic                wr_go_q, wr_go_d;
  logic                tx_done_q, tx_done_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_ready_q, wr_ready_d;
  logic [ADDR_W-1:0]   xlate_addr;
  logic [WORD_W-1:0]   line_words [WPL];

  region_xlate #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W)
  ) u_region_xlate (
    .cpu_addr    (cpu_addr),
    .region_base (region_base),
    .xlate_addr  (xlate_addr)
  );

  for (genvar gi = 0; gi < WPL; gi++) begin : g_words
    assign line_words[gi] = line_q[gi*WORD_W +: WORD_W];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    line_d      = line_q;
    host_addr_d = host_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (host_init && (op == OP_LOAD || op == OP_STORE)) begin
          host_addr_d = xlate_addr;
          idx_d       = '0;
          state_d     = (op == OP_LOAD) ? ST_RD_REQ : ST_WR_FILL;
        end
      end
      ST_RD_REQ:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (host_rd_ready) begin
          line_d  = host_rd_data;
          idx_d   = '0;
          state_d = ST_RD_STREAM;
        end
      end
      ST_RD_STREAM: begin
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_WR_FILL: begin
        if (cpu_wr_valid) begin
          for (int k = 0; k < WPL; k++) begin
            if (idx_q == IDX_W'(k)) line_d[k*WORD_W +: WORD_W] = cpu_wr_data;
          end
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_WR_REQ;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_WR_REQ:  state_d = ST_WR_WAIT;
      ST_WR_WAIT: if (host_wr_ready) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Status outputs are registered copies of the next-state decode.
    ready_d    = (state_d == ST_IDLE);
    rd_go_d    = (state_d == ST_RD_REQ);
    wr_go_d    = (state_d == ST_WR_REQ);
    tx_done_d  = (state_d == ST_DONE);
    rd_valid_d = (state_d == ST_RD_STREAM);
    wr_ready_d = (state_d == ST_WR_FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      line_q      <= '0;
      host_addr_q <= '0;
      ready_q     <= 1'b1;
      rd_go_q     <= 1'b0;
      wr_go_q     <= 1'b0;
      tx_done_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      line_q      <= line_d;
      host_addr_q <= host_addr_d;
      ready_q     <= ready_d;
      rd_go_q     <= rd_go_d;
      wr_go_q     <= wr_go_d;
      tx_done_q   <= tx_done_d;
      rd_valid_q  <= rd_valid_d;
      wr_ready_q  <= wr_ready_d;
    end
  end

  always_comb begin
    cpu_rd_data = '0;
    for (int k = 0; k < WPL; k++) begin
      if (idx_q == IDX_W'(k)) cpu_rd_data = line_words[k];
    end
  end

  // The DMA pops/pushes follow the FIFO flags combinationally while waiting.
  assign host_re      = (state_q == ST_RD_WAIT) && host_rd_ready;
  assign host_we      = (state_q == ST_WR_WAIT) && host_wr_ready;
  assign host_wr_data = line_q;
  assign host_addr    = host_addr_q;
  assign ready        = ready_q;
  assign host_rd_go   = rd_go_q;
  assign host_wr_go   = wr_go_q;
  assign tx_done      = tx_done_q;
  assign cpu_rd_valid = rd_valid_q;
  assign cpu_wr_ready = wr_ready_q;

endmodule

// File: tb/tb_line_xfer_ctrl.sv
// Scoreboard bench: stimulus pushes expected words/lines, monitors pop and compare.
module tb_line_xfer_ctrl;
  import line_xfer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default geometry (32-bit words, 512-bit lines, 4 regions)
  logic         a_host_init, a_cpu_wr_valid, a_cpu_wr_ready, a_cpu_rd_valid, a_ready, a_tx_done;
  logic [1:0]   a_op;
  logic [63:0]  a_cpu_addr, a_host_addr;
  logic [255:0] a_region_base;
  logic [31:0]  a_cpu_wr_data, a_cpu_rd_data;
  logic         a_host_rd_go, a_host_wr_go, a_host_rd_ready, a_host_re, a_host_wr_ready, a_host_we;
  logic [511:0] a_host_rd_data, a_host_wr_data;

  // Instance B: 64-bit words, 128-bit lines, single region
  logic         b_host_init, b_cpu_wr_valid, b_cpu_wr_ready, b_cpu_rd_valid, b_ready, b_tx_done;
  logic [1:0]   b_op;
  logic [63:0]  b_cpu_addr, b_host_addr, b_region_base;
  logic [63:0]  b_cpu_wr_data, b_cpu_rd_data;
  logic         b_host_rd_go, b_host_wr_go, b_host_rd_ready, b_host_re, b_host_wr_ready, b_host_we;
  logic [127:0] b_host_rd_data, b_host_wr_data;

  line_xfer_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_n), .host_init(a_host_init), .op(a_op), .cpu_addr(a_cpu_addr),
    .region_base(a_region_base), .cpu_wr_data(a_cpu_wr_data), .cpu_wr_valid(a_cpu_wr_valid),
    .cpu_wr_ready(a_cpu_wr_ready), .cpu_rd_data(a_cpu_rd_data), .cpu_rd_valid(a_cpu_rd_valid),
    .ready(a_ready), .tx_done(a_tx_done), .host_addr(a_host_addr), .host_rd_go(a_host_rd_go),
    .host_wr_go(a_host_wr_go), .host_rd_ready(a_host_rd_ready), .host_re(a_host_re),
    .host_rd_data(a_host_rd_data), .host_wr_ready(a_host_wr_ready), .host_we(a_host_we),
    .host_wr_data(a_host_wr_data)
  );

  line_xfer_ctrl #(.WORD_W(64), .LINE_W(128), .ADDR_W(64), .NUM_REGIONS(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .host_init(b_host_init), .op(b_op), .cpu_addr(b_cpu_addr),
    .region_base(b_region_base), .cpu_wr_data(b_cpu_wr_data), .cpu_wr_valid(b_cpu_wr_valid),
    .cpu_wr_ready(b_cpu_wr_ready), .cpu_rd_data(b_cpu_rd_data), .cpu_rd_valid(b_cpu_rd_valid),
    .ready(b_ready), .tx_done(b_tx_done), .host_addr(b_host_addr), .host_rd_go(b_host_rd_go),
    .host_wr_go(b_host_wr_go), .host_rd_ready(b_host_rd_ready), .host_re(b_host_re),
    .host_rd_data(b_host_rd_data), .host_wr_ready(b_host_wr_ready), .host_we(b_host_we),
    .host_wr_data(b_host_wr_data)
  );

  int checks = 0;
  int failures = 0;
  int a_done_cnt = 0, a_rdgo_cnt = 0, a_wrgo_cnt = 0, b_done_cnt = 0;
  logic [31:0]  exp_a_rd[$];
  logic [511:0] exp_a_wr[$];
  logic [63:0]  exp_a_waddr[$];
  logic [63:0]  exp_b_rd[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit sel, input int start, output int cyc);
    cyc = start;
    while (!(sel ? b_tx_done : a_tx_done) && cyc < start + 200) begin
      tick();
      cyc++;
    end
    if (!(sel ? b_tx_done : a_tx_done))
      chk(sel ? "b_done_timeout" : "a_done_timeout", sel ? b_tx_done : a_tx_done, 1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_cpu_rd_valid) begin
        if (exp_a_rd.size() == 0) chk("a_rd_unexpected", a_cpu_rd_valid, 0);
        else chk("a_rd_word", a_cpu_rd_data, exp_a_rd.pop_front());
      end
      if (a_host_we) begin
        if (exp_a_wr.size() == 0) chk("a_we_unexpected", a_host_we, 0);
        else begin
          chk("a_wr_line", a_host_wr_data, exp_a_wr.pop_front());
          chk("a_wr_addr", a_host_addr, exp_a_waddr.pop_front());
        end
      end
      if (a_tx_done) begin
        a_done_cnt++;
        $display("txn A done host_addr=%h", a_host_addr);
      end
      if (a_host_rd_go) a_rdgo_cnt++;
      if (a_host_wr_go) a_wrgo_cnt++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (b_cpu_rd_valid) begin
        if (exp_b_rd.size() == 0) chk("b_rd_unexpected", b_cpu_rd_valid, 0);
        else chk("b_rd_word", b_cpu_rd_data, exp_b_rd.pop_front());
      end
      if (b_tx_done) begin
        b_done_cnt++;
        $display("txn B done host_addr=%h", b_host_addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int cyc, c, k, cnt_before, done_before, bad;
    bit v;
    a_host_init = 0; a_op = OP_IDLE; a_cpu_addr = '0; a_cpu_wr_data = '0; a_cpu_wr_valid = 0;
    a_host_rd_ready = 0; a_host_rd_data = '0; a_host_wr_ready = 1;
    a_region_base = {64'hFFFF_FFFF_FFFF_F000, 64'h0000_0000_0000_1000,
                     64'h0000_0000_2000_0000, 64'h0000_0000_0000_0000};
    b_host_init = 0; b_op = OP_IDLE; b_cpu_addr = '0; b_cpu_wr_data = '0; b_cpu_wr_valid = 0;
    b_host_rd_ready = 0; b_host_rd_data = '0; b_host_wr_ready = 0; b_region_base = 64'h1_0000_0000;

    // Reset values
    repeat (3) tick();
    chk("rst_ready", a_ready, 1);
    chk("rst_outs", {a_cpu_rd_valid, a_cpu_wr_ready, a_tx_done, a_host_rd_go, a_host_wr_go, a_host_re, a_host_we}, 0);
    chk("rst_addr", a_host_addr, 0);
    chk("rst_wr_data", a_host_wr_data, 0);
    rst_n = 1;
    tick();

    // LOAD, region 2, DMA data already waiting
    for (k = 0; k < 16; k++) begin
      a_host_rd_data[k*32 +: 32] = 32'hC0DE_0000 + 32'(k);
      exp_a_rd.push_back(32'hC0DE_0000 + 32'(k));
    end
    a_host_rd_ready = 1; a_host_init = 1; a_op = OP_LOAD; a_cpu_addr = 64'h8000_0000_0000_0040;
    tick();
    a_op = OP_IDLE; a_cpu_addr = 64'hFFFF_0000_0000_0000;
    chk("ld_addr", a_host_addr, 64'h1040);
    chk("ld_rd_go_c1", a_host_rd_go, 1);
    chk("ld_ready_low", a_ready, 0);
    tick();
    chk("ld_re_c2", a_host_re, 1);
    tick();
    wait_done(0, 3, cyc);
    chk("ld_done_cycle", cyc, 19);
    tick();
    chk("ld_ready_back", a_ready, 1);
    chk("ld_words_left", exp_a_rd.size(), 0);

    // STORE, region 1, valid drops every third cycle, junk data in gaps
    for (k = 0; k < 16; k++) exp_a_wr.push_back('0);
    exp_a_wr.delete();
    begin
      logic [511:0] line;
      for (k = 0; k < 16; k++) line[k*32 +: 32] = 32'hA0 + 32'(k);
      exp_a_wr.push_back(line);
    end
    exp_a_waddr.push_back(64'h2000_0100);
    done_before = a_done_cnt;
    a_op = OP_STORE; a_cpu_addr = 64'h4000_0000_0000_0100;
    tick();
    a_op = OP_IDLE;
    chk("st_wr_ready", a_cpu_wr_ready, 1);
    chk("st_addr", a_host_addr, 64'h2000_0100);
    k = 0; c = 1;
    while (k < 16 && c < 100) begin
      v = (c % 3 != 0);
      a_cpu_wr_valid = v;
      a_cpu_wr_data = v ? 32'hA0 + 32'(k) : 32'hBAD0_0000;
      tick();
      if (v) k++;
      c++;
    end
    a_cpu_wr_valid = 0; a_cpu_wr_data = 32'hDEAD_BEEF;
    wait_done(0, c, cyc);
    chk("st_done_cycle", cyc, 26);
    repeat (3) tick();
    chk("st_one_done", a_done_cnt - done_before, 1);
    chk("st_lines_left", exp_a_wr.size(), 0);

    // LOAD with DMA FIFO empty for 10 cycles of RD_WAIT
    a_host_rd_ready = 0;
    for (k = 0; k < 16; k++) begin
      a_host_rd_data[k*32 +: 32] = 32'h5A00_0000 + 32'(k) * 32'h11;
      exp_a_rd.push_back(32'h5A00_0000 + 32'(k) * 32'h11);
    end
    a_op = OP_LOAD; a_cpu_addr = 64'h0000_0000_0000_0200;
    tick();
    a_op = OP_IDLE;
    chk("stall_addr", a_host_addr, 64'h200);
    bad = 0;
    for (int i = 1; i <= 11; i++) begin
      if (a_host_re !== 1'b0 || a_cpu_rd_valid !== 1'b0) bad++;
      tick();
    end
    chk("stall_quiet", bad, 0);
    a_host_rd_ready = 1;
    #1;
    chk("stall_re", a_host_re, 1);
    wait_done(0, 12, cyc);
    chk("stall_done_cycle", cyc, 29);
    tick();

    // Commands that must not be accepted
    cnt_before = a_rdgo_cnt + a_wrgo_cnt;
    bad = 0;
    a_host_init = 0; a_op = OP_LOAD;
    repeat (5) begin tick(); if (a_ready !== 1'b1) bad++; end
    a_host_init = 1; a_op = 2'b11;
    repeat (5) begin tick(); if (a_ready !== 1'b1) bad++; end
    a_op = OP_IDLE;
    tick();
    chk("reject_ready", bad, 0);
    chk("reject_no_go", a_rdgo_cnt + a_wrgo_cnt - cnt_before, 0);

    // Reset while word 5 of a LOAD is on the bus
    for (k = 0; k < 16; k++) begin
      a_host_rd_data[k*32 +: 32] = 32'h7700_0000 + 32'(k);
      exp_a_rd.push_back(32'h7700_0000 + 32'(k));
    end
    a_op = OP_LOAD; a_cpu_addr = 64'hC000_0000_0000_0080;
    tick();
    a_op = OP_IDLE;
    chk("rs_addr", a_host_addr, 64'hFFFF_FFFF_FFFF_F080);
    repeat (7) tick();
    chk("rs_word5", a_cpu_rd_data, 32'h7700_0005);
    done_before = a_done_cnt;
    rst_n = 0;
    #1;
    chk("rs_ready", a_ready, 1);
    chk("rs_outs", {a_cpu_rd_valid, a_tx_done, a_host_re, a_host_rd_go}, 0);
    chk("rs_addr_clr", a_host_addr, 0);
    chk("rs_rd_data", a_cpu_rd_data, 0);
    chk("rs_popped", exp_a_rd.size(), 11);
    exp_a_rd.delete();
    tick(); tick();
    rst_n = 1;
    tick();
    begin
      logic [511:0] line;
      for (k = 0; k < 16; k++) line[k*32 +: 32] = 32'h3300 + 32'(k);
      exp_a_wr.push_back(line);
    end
    exp_a_waddr.push_back(64'h40);
    a_op = OP_STORE; a_cpu_addr = 64'h0000_0000_0000_0040;
    tick();
    a_op = OP_IDLE;
    for (k = 0; k < 16; k++) begin
      a_cpu_wr_valid = 1; a_cpu_wr_data = 32'h3300 + 32'(k);
      tick();
    end
    a_cpu_wr_valid = 0;
    wait_done(0, 17, cyc);
    chk("rs_st_done_cycle", cyc, 19);
    repeat (2) tick();
    chk("rs_one_done", a_done_cnt - done_before, 1);

    // Instance B: two-word line, single region
    b_host_rd_data = {64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444};
    exp_b_rd.push_back(64'h1111_2222_3333_4444);
    exp_b_rd.push_back(64'h5555_6666_7777_8888);
    b_host_rd_ready = 1; b_host_init = 1; b_op = OP_LOAD; b_cpu_addr = 64'h8000_0000_0000_0020;
    tick();
    b_op = OP_IDLE;
    chk("b_addr", b_host_addr, 64'h8000_0001_0000_0020);
    wait_done(1, 1, cyc);
    chk("b_done_cycle", cyc, 5);
    tick();
    chk("b_ready_back", b_ready, 1);
    chk("b_words_left", exp_b_rd.size(), 0);
    chk("b_one_done", b_done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
